// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg
//   Shared definitions for the raster-to-column line buffer:
//   - lb_state_t : PRIME/STREAM state encoding of the control FSM
//   - row_lsb()  : bit offset of a row slice inside the packed column bus
package line_buffer_pkg;

  typedef enum logic {
    ST_PRIME  = 1'b0,
    ST_STREAM = 1'b1
  } lb_state_t;

  // Row i of the column occupies bits [row_lsb(i) +: data_width].
  function automatic int row_lsb(input int row, input int data_width);
    return row * data_width;
  endfunction

endpackage

// File: rtl/line_buffer_line_mem.sv
// line_buffer_line_mem
//   One stored image line: simple dual-port RAM, DEPTH x WIDTH, with a
//   registered read port that returns the old contents when the same address
//   is written in the same cycle. Contents are not reset.
// Ports:
//   clk      : clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write address (column)
//   wr_data  : write data
//   rd_en    : read strobe; rd_data only changes when this is high
//   rd_addr  : read address (column)
//   rd_data  : registered read data
module line_buffer_line_mem #(
  parameter int DEPTH      = 640,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/line_buffer.sv
// line_buffer
//   Raster-to-column converter. Buffers the previous BLOCK_HEIGHT-1 lines and,
//   once primed, emits one BLOCK_HEIGHT-pixel column per accepted pixel with
//   independent per-row valid/ready.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   in_pixel   : raster pixel
//   in_valid   : in_pixel valid
//   in_last    : last pixel of frame (qualified by a transfer)
//   in_ready   : pixel can be accepted this cycle
//   out_pixels : column, row 0 (oldest line) in the LSBs
//   out_valid  : per-row valid
//   out_ready  : per-row ready
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_PRIME  | fewer than BLOCK_HEIGHT-1 lines stored; transfers only fill
// ST_STREAM | every transfer loads a full column into the output
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_HEIGHT = 3,
  parameter int IMAGE_WIDTH  = 640,
  parameter int COL_WIDTH    = $clog2(IMAGE_WIDTH),
  parameter int OUTPUT_WIDTH = DATA_WIDTH * BLOCK_HEIGHT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_pixels,
  output logic [BLOCK_HEIGHT-1:0] out_valid,
  input  logic [BLOCK_HEIGHT-1:0] out_ready
);

  localparam int NUM_MEM    = BLOCK_HEIGHT - 1;
  localparam int LINE_WIDTH = $clog2(BLOCK_HEIGHT);
  localparam logic [COL_WIDTH-1:0]  COL_LAST   = COL_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [LINE_WIDTH-1:0] LINE_FULL  = LINE_WIDTH'(BLOCK_HEIGHT - 1);
  localparam logic [LINE_WIDTH-1:0] LINE_PRIME = LINE_WIDTH'(BLOCK_HEIGHT - 2);

  lb_state_t                 state, state_n;
  logic [COL_WIDTH-1:0]      col, col_n;
  logic [LINE_WIDTH-1:0]     line_cnt, line_n;
  logic [BLOCK_HEIGHT-1:0]   pending, pending_n;
  logic                      xfer, load;

  logic                      xfer_d, load_d, byp_hit, byp_set;
  logic [COL_WIDTH-1:0]      col_d;
  logic [DATA_WIDTH-1:0]     pix_d;
  logic [OUTPUT_WIDTH-1:0]   hold_q, col_now;

  logic [NUM_MEM-1:0][DATA_WIDTH-1:0] ram_rd, rd_eff, wr_data, byp_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_PRIME;
      col      <= '0;
      line_cnt <= '0;
      pending  <= '0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      line_cnt <= line_n;
      pending  <= pending_n;
    end
  end

  always_comb begin
    state_n  = state;
    col_n    = col;
    line_n   = line_cnt;
    in_ready = 1'b1;
    if (state == ST_STREAM) begin
      in_ready = ((pending & ~out_ready) == '0);
    end
    xfer = in_valid & in_ready;
    load = xfer & (state == ST_STREAM);

    // A new column overrides any clears in the same cycle.
    pending_n = pending & ~out_ready;
    if (load) begin
      pending_n = '1;
    end

    if (xfer) begin
      if (in_last) begin
        col_n   = '0;
        line_n  = '0;
        state_n = ST_PRIME;
      end else if (col == COL_LAST) begin
        col_n = '0;
        if (line_cnt != LINE_FULL) begin
          line_n = line_cnt + 1'b1;
        end
        if ((state == ST_PRIME) && (line_cnt == LINE_PRIME)) begin
          state_n = ST_STREAM;
        end
      end else begin
        col_n = col + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ line memories
  // The upward shift needs the old contents, which the synchronous read
  // only delivers one cycle after the transfer, so each write is issued a
  // cycle late to the remembered column. If the very next transfer reads
  // that same column (in_last at column 0), the RAM returns pre-write
  // data; byp_data supplies the value being written instead.
  assign byp_set = xfer & xfer_d & (col == col_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_d  <= 1'b0;
      load_d  <= 1'b0;
      byp_hit <= 1'b0;
      col_d   <= '0;
      pix_d   <= '0;
      hold_q  <= '0;
    end else begin
      xfer_d  <= xfer;
      load_d  <= load;
      byp_hit <= byp_set;
      if (xfer) begin
        col_d <= col;
        pix_d <= in_pixel;
      end
      if (load_d) begin
        hold_q <= col_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byp_set) begin
      byp_data <= wr_data;
    end
  end

  always_comb begin
    rd_eff = byp_hit ? byp_data : ram_rd;
    for (int j = 0; j < NUM_MEM - 1; j++) begin
      wr_data[j] = rd_eff[j+1];
    end
    wr_data[NUM_MEM-1] = pix_d;
  end

  for (genvar j = 0; j < NUM_MEM; j++) begin : g_mem
    line_buffer_line_mem #(
      .DEPTH      (IMAGE_WIDTH),
      .WIDTH      (DATA_WIDTH),
      .ADDR_WIDTH (COL_WIDTH)
    ) u_line_mem (
      .clk     (clk),
      .wr_en   (xfer_d),
      .wr_addr (col_d),
      .wr_data (wr_data[j]),
      .rd_en   (xfer),
      .rd_addr (col),
      .rd_data (ram_rd[j])
    );
  end

  // ------------------------------------------------------------- output
  always_comb begin
    col_now = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      col_now[row_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = rd_eff[i];
    end
    col_now[row_lsb(NUM_MEM, DATA_WIDTH) +: DATA_WIDTH] = pix_d;
  end

  // The fresh column is only on the RAM outputs for the cycle after the
  // load; hold_q keeps it stable afterwards while priming reads continue.
  assign out_pixels = load_d ? col_now : hold_q;
  assign out_valid  = pending;

endmodule

// File: tb/tb_line_buffer.sv
module tb_line_buffer;

  localparam int DW = 8;
  localparam int BH = 3;
  localparam int IW = 4;
  localparam int OW = DW * BH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_pixel;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_pixels;
  logic [BH-1:0] out_valid;
  logic [BH-1:0] out_ready;

  int checks = 0;
  int passes = 0;

  line_buffer #(
    .DATA_WIDTH   (DW),
    .BLOCK_HEIGHT (BH),
    .IMAGE_WIDTH  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_pixels (out_pixels),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: line memories as plain arrays shifted on every transfer.
  logic [DW-1:0] m_mem [BH-1][IW];
  int            m_col    = 0;
  int            m_line   = 0;
  bit            m_stream = 1'b0;
  bit            exp_due  = 1'b0;
  logic [OW-1:0] sb_exp;
  logic [OW-1:0] sb_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      m_col    = 0;
      m_line   = 0;
      m_stream = 1'b0;
      exp_due  = 1'b0;
      sb_q.delete();
    end else begin
      if (exp_due) begin
        sb_exp = sb_q.pop_front();
        check("sb_pixels", 32'(out_pixels), 32'(sb_exp));
        check("sb_valid", 32'(out_valid), 32'(3'b111));
      end
      exp_due = 1'b0;
      if (in_valid && in_ready) begin
        if (m_stream) begin
          sb_exp = '0;
          for (int j = 0; j < BH - 1; j++) sb_exp[j*DW +: DW] = m_mem[j][m_col];
          sb_exp[(BH-1)*DW +: DW] = in_pixel;
          sb_q.push_back(sb_exp);
          exp_due = 1'b1;
        end
        for (int j = 0; j < BH - 2; j++) m_mem[j][m_col] = m_mem[j+1][m_col];
        m_mem[BH-2][m_col] = in_pixel;
        if (in_last) begin
          m_col    = 0;
          m_line   = 0;
          m_stream = 1'b0;
        end else if (m_col == IW - 1) begin
          m_col = 0;
          if (m_line < BH - 1) m_line++;
          if (m_line == BH - 1) m_stream = 1'b1;
        end else begin
          m_col++;
        end
      end
    end
  end

  // Inputs only change at posedge+1; returns at posedge+1 after the transfer.
  task automatic send(input int line, input int c, input logic last);
    int n = 0;
    @(posedge clk); #1;
    in_pixel = 8'(line * 16 + c);
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    in_pixel  = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 3'b111;
    rst       = 1'b0;

    #12;
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_pixels", 32'(out_pixels), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #3;
    rst = 1'b1;

    // Priming: lines 0-1 back to back.
    @(posedge clk); #1;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < IW; c++) begin
        in_pixel = 8'(l * 16 + c);
        in_valid = 1'b1;
        @(negedge clk);
        check("prime_ready", 32'(in_ready), 32'(1));
        check("prime_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("prime_valid_end", 32'(out_valid), 32'(0));

    // First columns of line 2.
    send(2, 0, 1'b0);
    @(negedge clk);
    check("first_col", 32'(out_pixels), 32'h201000);
    check("first_valid", 32'(out_valid), 32'(3'b111));
    send(2, 1, 1'b0);
    send(2, 2, 1'b0);
    send(2, 3, 1'b0);
    @(negedge clk);
    check("last_col", 32'(out_pixels), 32'h231303);

    // Line wrap plus skewed drain.
    @(posedge clk); #1;
    out_ready = 3'b000;
    send(3, 0, 1'b0);
    out_ready = 3'b001;
    @(negedge clk);
    check("wrap_col", 32'(out_pixels), 32'h302010);
    check("skew_v0", 32'(out_valid), 32'(3'b111));
    check("skew_r0", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    out_ready = 3'b010;
    @(negedge clk);
    check("skew_v1", 32'(out_valid), 32'(3'b110));
    check("skew_r1", 32'(in_ready), 32'(0));
    check("skew_p1", 32'(out_pixels), 32'h302010);
    @(posedge clk); #1;
    out_ready = 3'b100;
    @(negedge clk);
    check("skew_v2", 32'(out_valid), 32'(3'b100));
    check("skew_r2", 32'(in_ready), 32'(1));
    check("skew_p2", 32'(out_pixels), 32'h302010);
    @(posedge clk); #1;
    out_ready = 3'b111;
    @(negedge clk);
    check("skew_v3", 32'(out_valid), 32'(0));
    check("skew_p3", 32'(out_pixels), 32'h302010);

    // Full-rate burst for the rest of line 3.
    @(posedge clk); #1;
    for (int c = 1; c < IW; c++) begin
      in_pixel = 8'(3 * 16 + c);
      in_valid = 1'b1;
      @(negedge clk);
      check("burst_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset while pending = 101.
    @(posedge clk); #1;
    out_ready = 3'b000;
    send(4, 0, 1'b0);
    out_ready = 3'b010;
    @(posedge clk); #1;
    out_ready = 3'b000;
    @(negedge clk);
    check("pend_101", 32'(out_valid), 32'(3'b101));
    #2;
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'(0));
    check("mrst_pixels", 32'(out_pixels), 32'(0));
    check("mrst_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    out_ready = 3'b111;

    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < IW; c++) begin
        send(l, c, 1'b0);
        @(negedge clk);
        check("rprime_valid", 32'(out_valid), 32'(0));
      end
    end
    send(2, 0, 1'b0);
    @(negedge clk);
    check("rfirst_valid", 32'(out_valid), 32'(3'b111));
    check("rfirst_col", 32'(out_pixels), 32'h201000);

    // Short frame: in_last on line 2 col 1.
    send(2, 1, 1'b1);
    @(negedge clk);
    check("short_col", 32'(out_pixels), 32'h211101);
    check("short_valid", 32'(out_valid), 32'(3'b111));
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < IW; c++) begin
        send(l, c, 1'b0);
        @(negedge clk);
        check("sprime_valid", 32'(out_valid), 32'(0));
      end
    end
    send(2, 0, 1'b0);
    @(negedge clk);
    check("sresume_valid", 32'(out_valid), 32'(3'b111));
    check("sresume_col", 32'(out_pixels), 32'h201000);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
